dm_arbiter: RTL and testbench

- Single-port data-memory arbiter in the MEM stage, between two requesters and the shared data memory.
- Requester 1: pipeline load/store, which has priority.
- Requester 2: external port (loader/debug/DMA), which has a starvation guard and burst lock.
- The arbiter drives the memory WE/ADDRESS/DATA, returns read data, and raises a pipeline stall when the CPU loses arbitration.
- Data memory: asynchronous read, synchronous write on rising CLK.

---
 rtl/dm_arb_pkg.sv | 23 ++
 rtl/dm_arbiter_sat_counter.sv | 27 ++
 rtl/dm_arbiter.sv | 151 +++++++++++++++
 tb/tb_dm_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional round-robin contention is enabled with DM_ARB_RR_EN.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam int AW_DEF        = 10;
    localparam int DW_DEF        = 32;
    localparam int MAX_WAIT_DEF  = 3;
    localparam int MAX_BURST_DEF = 4;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

    localparam int WAIT_W_DEF  = cnt_w(MAX_WAIT_DEF);
    localparam int BURST_W_DEF = cnt_w(MAX_BURST_DEF);

endpackage

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter; clr with inc together restarts the count at 1.
// Used for the ext starvation and burst counters.
module sat_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAXV = W'(MAX);
    localparam logic [W-1:0] ONE  = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && count != MAXV) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU priority, ext starvation guard and lock.
// Define DM_ARB_RR_EN for alternating grants on uncontended-by-force cycles.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          dm_WE,
    output logic [AW-1:0] dm_ADDRESS,
    output logic [DW-1:0] dm_DATA,
    input  logic [DW-1:0] dm_Q
);

    localparam int WAIT_W  = cnt_w(MAX_WAIT);
    localparam int BURST_W = cnt_w(MAX_BURST);

    owner_e               owner_q;
    owner_e               owner_d;
    logic [WAIT_W-1:0]    wait_q;
    logic [BURST_W-1:0]   burst_q;
    logic                 ext_rvalid_q;
    logic [DW-1:0]        ext_rdata_q;
    logic                 wait_hit;
    logic                 lock_hold;
    logic                 ext_force;
    logic                 cpu_gnt;
    logic                 ext_denied;

    assign wait_hit  = (wait_q == WAIT_W'(MAX_WAIT));
    assign lock_hold = (owner_q == OWN_EXT) && ext_lock
                     && (burst_q < BURST_W'(MAX_BURST));
    assign ext_force = ext_req & (wait_hit | lock_hold);

`ifdef DM_ARB_RR_EN
    logic contested;
    logic cpu_lost_q;

    assign contested = cpu_req & ext_req;

    // Last cycle's owner yields, unless the CPU already yielded a contest.
    always_comb begin
        cpu_gnt = cpu_req & ~ext_force;
        if (contested && !ext_force) begin
            cpu_gnt = (owner_q != OWN_CPU) | cpu_lost_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_lost_q <= 1'b0;
        end else begin
            cpu_lost_q <= contested & ~cpu_gnt;
        end
    end
`else
    assign cpu_gnt = cpu_req & ~ext_force;
`endif

    assign ext_gnt    = ext_req & ~cpu_gnt;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rdata  = dm_Q;
    assign ext_denied = ext_req & ~ext_gnt;

    always_comb begin
        dm_WE      = 1'b0;
        dm_ADDRESS = '0;
        dm_DATA    = '0;
        unique case (1'b1)
            cpu_gnt: begin
                dm_WE      = cpu_we;
                dm_ADDRESS = cpu_addr;
                dm_DATA    = cpu_wdata;
            end
            ext_gnt: begin
                dm_WE      = ext_we;
                dm_ADDRESS = ext_addr;
                dm_DATA    = ext_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d = OWN_IDLE;
        unique case (1'b1)
            cpu_gnt: owner_d = OWN_CPU;
            ext_gnt: owner_d = OWN_EXT;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q      <= OWN_IDLE;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            ext_rvalid_q <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata_q <= dm_Q;
            end
        end
    end

    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

    sat_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) u_wait (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (ext_denied),
        .clr   (~ext_denied),
        .count (wait_q)
    );

    // A grant arriving from a non-EXT owner restarts the burst at 1.
    sat_counter #(
        .W   (BURST_W),
        .MAX (MAX_BURST)
    ) u_burst (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (ext_gnt),
        .clr   (~ext_gnt | (owner_q != OWN_EXT)),
        .count (burst_q)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter against a cycle-level reference model.
// Also exercises directed scenarios; honours DM_ARB_RR_EN when defined.
module tb_dm_arbiter;

    localparam int AW        = 10;
    localparam int DW        = 32;
    localparam int MAX_WAIT  = 3;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic          ext_lock = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          dm_we;
    logic [AW-1:0] dm_address;
    logic [DW-1:0] dm_data;
    logic [DW-1:0] dm_q;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int unsigned checks = 0;
    int unsigned errors = 0;

    int          m_owner;
    int          m_wait;
    int          m_burst;
    bit          m_cpu_lost;
    bit          m_rvalid;
    logic [DW-1:0] m_rdata;

    logic          obs_gnt;
    logic          obs_stall;
    logic          obs_we;
    logic [DW-1:0] obs_rdata;
    logic          obs_rvalid;
    logic [DW-1:0] obs_erdata;

    logic [7:0] gnt_bits;
    logic [7:0] stall_bits;

    always #5 clk = ~clk;

    assign dm_q = mem[dm_address];

    dm_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .dm_WE      (dm_we),
        .dm_ADDRESS (dm_address),
        .dm_DATA    (dm_data),
        .dm_Q       (dm_q)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_wait     = 0;
        m_burst    = 0;
        m_cpu_lost = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
    endtask

    // One bus cycle: drive, compare against the model, advance both.
    task automatic step(input bit creq, input bit cwe,
                        input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                        input bit ereq, input bit ewe, input bit elock,
                        input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd);
        bit            frc;
        bit            cg;
        bit            eg;
        bit            xwe;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic          s_we;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        @(negedge clk);
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        ext_req   = ereq;
        ext_we    = ewe;
        ext_lock  = elock;
        ext_addr  = eaddr;
        ext_wdata = ewd;
        #1;
        frc = ereq && (m_wait == MAX_WAIT
              || (m_owner == 2 && elock && m_burst < MAX_BURST));
        cg = creq && !frc;
`ifdef DM_ARB_RR_EN
        if (creq && ereq && !frc)
            cg = (m_owner != 1) || m_cpu_lost;
`endif
        eg  = ereq && !cg;
        xwe = 1'b0;
        xa  = '0;
        xd  = '0;
        if (cg) begin
            xwe = cwe;
            xa  = caddr;
            xd  = cwd;
        end else if (eg) begin
            xwe = ewe;
            xa  = eaddr;
            xd  = ewd;
        end
        check("cpu_stall", DW'(cpu_stall), DW'(creq && !cg));
        check("ext_gnt", DW'(ext_gnt), DW'(eg));
        check("dm_we", DW'(dm_we), DW'(xwe));
        check("dm_addr", DW'(dm_address), DW'(xa));
        check("dm_data", dm_data, xd);
        check("cpu_rdata", cpu_rdata, ref_mem[xa]);
        check("ext_rvalid", DW'(ext_rvalid), DW'(m_rvalid));
        check("ext_rdata", ext_rdata, m_rdata);
        obs_gnt    = ext_gnt;
        obs_stall  = cpu_stall;
        obs_we     = dm_we;
        obs_rdata  = cpu_rdata;
        obs_rvalid = ext_rvalid;
        obs_erdata = ext_rdata;
        s_we = dm_we;
        s_a  = dm_address;
        s_d  = dm_data;
        @(posedge clk);
        #1;
        if (s_we)
            mem[s_a] = s_d;
        m_cpu_lost = creq && ereq && !cg;
        m_rvalid   = eg && !ewe;
        if (eg && !ewe)
            m_rdata = ref_mem[eaddr];
        if (xwe)
            ref_mem[xa] = xd;
        if (eg)
            m_burst = (m_owner == 2) ? ((m_burst < MAX_BURST) ? m_burst + 1
                                                              : MAX_BURST)
                                     : 1;
        else
            m_burst = 0;
        if (ereq && !eg)
            m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else
            m_wait = 0;
        m_owner = cg ? 1 : (eg ? 2 : 0);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        model_reset();
        #2;
        check("rst_rvalid", DW'(ext_rvalid), '0);
        check("rst_rdata", ext_rdata, '0);
        check("rst_stall", DW'(cpu_stall), '0);
        check("rst_gnt", DW'(ext_gnt), '0);
        check("rst_we", DW'(dm_we), '0);
        #5;
        rst_n = 1'b1;

        step(1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        check("st_stall", DW'(obs_stall), '0);
        check("st_we", DW'(obs_we), 1);
        step(1, 0, 10'h005, '0, 0, 0, 0, '0, '0);
        check("ld_data", obs_rdata, 32'hDEADBEEF);

        step(0, 0, '0, '0, 1, 0, 0, 10'h005, '0);
        check("ext_gnt_n", DW'(obs_gnt), 1);
        idle();
        check("ext_rv_n1", DW'(obs_rvalid), 1);
        check("ext_rd_n1", obs_erdata, 32'hDEADBEEF);
        idle();
        check("ext_rv_n2", DW'(obs_rvalid), 0);

        for (int i = 0; i < 8; i++) begin
            step(1, 0, 10'h001, '0, 1, 0, 0, 10'h002, '0);
            gnt_bits[i]   = obs_gnt;
            stall_bits[i] = obs_stall;
        end
`ifdef DM_ARB_RR_EN
        check("rr_gnt", DW'(gnt_bits), DW'(8'hAA));
        check("rr_stall", DW'(stall_bits), DW'(8'hAA));
`else
        check("starve_gnt", DW'(gnt_bits), DW'(8'h88));
        check("starve_stall", DW'(stall_bits), DW'(8'h88));
`endif

        idle();
        step(0, 0, '0, '0, 1, 0, 1, 10'h003, '0);
        gnt_bits   = '0;
        stall_bits = '0;
        gnt_bits[0]   = obs_gnt;
        stall_bits[0] = obs_stall;
        for (int i = 1; i < 5; i++) begin
            step(1, 0, 10'h004, '0, 1, 0, 1, 10'h003, '0);
            gnt_bits[i]   = obs_gnt;
            stall_bits[i] = obs_stall;
        end
        check("burst_gnt", DW'(gnt_bits[4:0]), DW'(5'b01111));
        check("burst_stall", DW'(stall_bits[4:0]), DW'(5'b01110));

        idle();
        step(0, 0, '0, '0, 1, 0, 0, 10'h005, '0);
        @(negedge clk);
        cpu_req  = 1'b0;
        ext_req  = 1'b0;
        ext_lock = 1'b0;
        #1;
        check("pre_rst_rv", DW'(ext_rvalid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rv", DW'(ext_rvalid), 0);
        check("async_rst_rd", ext_rdata, '0);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 10'h005, '0, 0, 0, 0, '0, '0);
        check("post_rst_stall", DW'(obs_stall), 0);
        check("post_rst_ld", obs_rdata, 32'hDEADBEEF);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
